// File: rtl/fetch_unit_if.sv
// Fetch unit port bundle: redirect, instruction-memory bus and instruction output.
//   master : fetch unit side (drives o_* signals)
//   slave  : environment side (memory, consumer, redirect source)
interface fetch_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_addr;
  logic            o_redirect_misaligned;
  logic            o_imem_req;
  logic [XLEN-1:0] o_imem_addr;
  logic            i_imem_gnt;
  logic            i_imem_rvalid;
  logic [XLEN-1:0] i_imem_rdata;
  logic            o_inst_valid;
  logic [XLEN-1:0] o_inst_data;
  logic [XLEN-1:0] o_inst_pc;
  logic            i_inst_ready;
  logic [CW-1:0]   o_count;

  modport master (
    input  i_redirect, i_redirect_addr, i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_inst_ready,
    output o_redirect_misaligned, o_imem_req, o_imem_addr, o_inst_valid, o_inst_data,
           o_inst_pc, o_count
  );

  modport slave (
    output i_redirect, i_redirect_addr, i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_inst_ready,
    input  o_redirect_misaligned, o_imem_req, o_imem_addr, o_inst_valid, o_inst_data,
           o_inst_pc, o_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues pipelined requests to a
// variable-latency instruction memory, buffers responses with their PCs in a
// DEPTH-entry prefetch queue and flushes on branch/trap redirects.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - fetch_unit_if.master: redirect in, imem req/gnt/rvalid bus, instruction
//          head (valid/data/pc/ready), occupancy count, misaligned-redirect pulse
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int unsigned     PW   = $clog2(DEPTH);
  localparam int unsigned     CW   = PW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(4);

  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic            misaligned;

  logic            req;
  logic            grant;
  logic            redirect_ok;
  logic            redirect_bad;
  logic            push;
  logic            pop;
  logic [CW:0]     credit;
  logic [CW-1:0]   outstanding_next;

  // Credit check counts queued plus in-flight entries so a response always has a slot;
  // a same-cycle pop is deliberately not credited.
  always_comb begin
    credit           = (CW+1)'(count) + (CW+1)'(outstanding);
    req              = !rst && (credit < (CW+1)'(DEPTH));
    grant            = req && bus.i_imem_gnt;
    redirect_ok      = bus.i_redirect && (bus.i_redirect_addr[1:0] == 2'b00);
    redirect_bad     = bus.i_redirect && (bus.i_redirect_addr[1:0] != 2'b00);
    push             = bus.i_imem_rvalid && (drop == '0) && !redirect_ok;
    pop              = (count != '0) && bus.i_inst_ready && !redirect_ok;
    outstanding_next = outstanding + CW'(grant) - CW'(bus.i_imem_rvalid);
  end

  // Queue payload storage; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= resp_pc;
      q_data[wr_ptr] <= bus.i_imem_rdata;
    end
  end

  // PCs, pointers and in-flight bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      misaligned  <= 1'b0;
    end else begin
      misaligned  <= redirect_bad;
      outstanding <= outstanding_next;
      if (redirect_ok) begin
        // Everything still in flight after this edge belongs to the old stream.
        fetch_pc <= bus.i_redirect_addr;
        resp_pc  <= bus.i_redirect_addr;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop     <= (outstanding_next > FULL) ? FULL : outstanding_next;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + STEP;
        end
        if (push) begin
          resp_pc <= resp_pc + STEP;
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (bus.i_imem_rvalid && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (push && !pop) begin
          count <= count + CW'(1);
        end else if (pop && !push) begin
          count <= count - CW'(1);
        end
      end
    end
  end

  // A response into a full queue means the memory broke the one-response-per-grant contract.
  always_ff @(posedge clk) begin
    if (!rst && bus.i_imem_rvalid) begin
      assert (count != FULL);
    end
  end

  assign bus.o_imem_req            = req;
  assign bus.o_imem_addr           = fetch_pc;
  assign bus.o_inst_valid          = (count != '0);
  assign bus.o_inst_data           = q_data[rd_ptr];
  assign bus.o_inst_pc             = q_pc[rd_ptr];
  assign bus.o_count               = count;
  assign bus.o_redirect_misaligned = misaligned;
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: in-order variable-latency memory model, consumer-side
// scoreboard, redirect vector table and hand-written multi-cycle sequences.
module tb_fetch_unit;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          NVEC     = 6;

  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
  typedef struct {
    logic [31:0] addr;
    int          lat;
    bit          lat_rand;
    bit          gnt_rand;
    bit          rdy_rand;
    bit          exp_mis;
    logic [31:0] exp_first;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  fetch_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  ent_t        sb[$];
  pend_t       mq[$];
  logic [31:0] exp_fetch;
  int          cyc;
  int          pops;
  int          grants;
  int          checks;
  int          errors;
  int          lat;
  bit          lat_rand;
  bit          gnt_rand;
  bit          rdy_rand;
  logic        ready_hold;
  vec_t        vecs[NVEC];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory, consumer and scoreboard; acts on the falling edge for the next rising edge.
  initial begin : model
    logic  exp_req;
    bit    redir_now;
    pend_t p;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.i_inst_ready = rdy_rand ? 1'($urandom_range(1, 0)) : ready_hold;
      if (rst) begin
        bus.i_imem_rvalid = 1'b0;
        bus.i_imem_gnt    = 1'b0;
      end else begin
        redir_now = bus.i_redirect && (bus.i_redirect_addr[1:0] == 2'b00);
        exp_req   = (sb.size() + mq.size()) < DEPTH;
        chk("count", 32'(bus.o_count), 32'(sb.size()));
        chk("valid", 32'(bus.o_inst_valid), 32'(sb.size() != 0));
        chk("req", 32'(bus.o_imem_req), 32'(exp_req));
        if (exp_req) chk("addr", bus.o_imem_addr, exp_fetch);
        if (bus.o_inst_valid && sb.size() != 0) begin
          chk("head_pc", bus.o_inst_pc, sb[0].pc);
          chk("head_data", bus.o_inst_data, sb[0].data);
          if (bus.i_inst_ready && !redir_now) begin
            void'(sb.pop_front());
            pops++;
          end
        end
        bus.i_imem_rvalid = 1'b0;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
          p = mq.pop_front();
          bus.i_imem_rvalid = 1'b1;
          bus.i_imem_rdata  = inst_of(p.addr);
          if (!p.stale && !redir_now) sb.push_back('{p.addr, inst_of(p.addr)});
        end
        bus.i_imem_gnt = gnt_rand ? 1'($urandom_range(1, 0)) : 1'b1;
        if (exp_req && bus.i_imem_gnt) begin
          mq.push_back('{exp_fetch, cyc + (lat_rand ? int'($urandom_range(4, 1)) : lat), 1'b0});
          grants++;
          exp_fetch = exp_fetch + 32'd4;
        end
        if (redir_now) begin
          foreach (mq[i]) mq[i].stale = 1'b1;
          sb.delete();
          exp_fetch = bus.i_redirect_addr;
        end
      end
    end
  end

  // Memory is reset alongside the fetch unit, so the model forgets everything in flight.
  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    mq.delete();
    exp_fetch         = RESET_PC;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_gnt    = 1'b0;
    bus.i_redirect    = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.o_inst_valid), 32'd0);
    chk("rst_count", 32'(bus.o_count), 32'd0);
    chk("rst_req", 32'(bus.o_imem_req), 32'd0);
    chk("rst_mis", 32'(bus.o_redirect_misaligned), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rel_req", 32'(bus.o_imem_req), 32'd1);
    chk("rel_addr", bus.o_imem_addr, RESET_PC);
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.o_inst_valid) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    bit found;
    int pops0;
    int grants0;

    vecs[0] = '{32'h0000_0100, 3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100};
    vecs[1] = '{32'h0000_0102, 3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[2] = '{32'hFFFF_FFF8, 2, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8};
    vecs[3] = '{32'h0000_0001, 2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0000};
    vecs[4] = '{32'h0000_0040, 2, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0040};
    vecs[5] = '{32'h0000_1000, 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1000};

    checks = 0; errors = 0; pops = 0; grants = 0;
    lat = 1; lat_rand = 1'b0; gnt_rand = 1'b0; rdy_rand = 1'b0; ready_hold = 1'b1;
    exp_fetch = RESET_PC;
    rst = 1'b1;
    bus.i_redirect = 1'b0; bus.i_redirect_addr = '0;
    bus.i_imem_gnt = 1'b0; bus.i_imem_rvalid = 1'b0; bus.i_imem_rdata = '0;
    bus.i_inst_ready = 1'b0;
    @(posedge clk); #2;
    do_reset();

    // Streaming: one instruction per cycle once the pipe is full.
    repeat (10) @(posedge clk);
    #2 pops0 = pops;
    repeat (20) @(posedge clk);
    #2 chk("throughput", 32'(pops - pops0), 32'd20);

    // Async reset with two entries queued.
    ready_hold = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_count == 3'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("two_queued", 32'(found), 32'd1);
    #2 do_reset();

    // Backpressure: credit stops requests at four, resumes at 16 once draining.
    grants0 = grants;
    repeat (10) @(posedge clk);
    #2;
    chk("bp_grants", 32'(grants - grants0), 32'd4);
    chk("bp_count", 32'(bus.o_count), 32'd4);
    chk("bp_req", 32'(bus.o_imem_req), 32'd0);
    chk("bp_next_addr", bus.o_imem_addr, 32'h0000_0010);
    ready_hold = 1'b1;
    repeat (20) @(posedge clk);

    // Redirect vector table.
    for (int v = 0; v < NVEC; v++) begin
      lat = vecs[v].lat; lat_rand = vecs[v].lat_rand;
      gnt_rand = vecs[v].gnt_rand; rdy_rand = vecs[v].rdy_rand;
      ready_hold = 1'b1;
      repeat (12) @(posedge clk);
      #2;
      bus.i_redirect = 1'b1;
      bus.i_redirect_addr = vecs[v].addr;
      @(posedge clk);
      #2 bus.i_redirect = 1'b0;
      chk("mis_pulse", 32'(bus.o_redirect_misaligned), 32'(vecs[v].exp_mis));
      if (!vecs[v].exp_mis) chk("cnt_after_redir", 32'(bus.o_count), 32'd0);
      @(posedge clk);
      #2 chk("mis_clear", 32'(bus.o_redirect_misaligned), 32'd0);
      if (!vecs[v].exp_mis) begin
        wait_valid(found);
        chk("redir_found", 32'(found), 32'd1);
        chk("redir_first_pc", bus.o_inst_pc, vecs[v].exp_first);
      end
    end

    // Redirect coinciding with grant, response and pop.
    lat = 1; lat_rand = 1'b0; gnt_rand = 1'b0; rdy_rand = 1'b0; ready_hold = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_req", 32'(bus.o_imem_req), 32'd1);
    chk("pre_valid", 32'(bus.o_inst_valid), 32'd1);
    chk("pre_inflight", 32'(mq.size()), 32'd1);
    #1;
    bus.i_redirect = 1'b1;
    bus.i_redirect_addr = 32'h0000_0300;
    @(posedge clk);
    #2 bus.i_redirect = 1'b0;
    chk("same_cnt", 32'(bus.o_count), 32'd0);
    chk("same_valid", 32'(bus.o_inst_valid), 32'd0);
    wait_valid(found);
    chk("same_found", 32'(found), 32'd1);
    chk("same_first_pc", bus.o_inst_pc, 32'h0000_0300);
    repeat (10) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end that replaces the direct PC-to-instruction-memory path of the single-cycle core.
- Owns the fetch PC and issues pipelined requests to an instruction memory with variable latency.
- Buffers returned instructions with their PCs in a DEPTH-entry prefetch queue.
- Applies branch/trap redirects by flushing the queue and discarding in-flight responses.

Parameters:
- XLEN, 32, width of the PC, address and instruction data.
- DEPTH, 4, prefetch queue entries; must be a power of 2, ≥2.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_redirect  input  1  branch/trap redirect request.
- i_redirect_addr  input  XLEN  redirect target.
- o_redirect_misaligned  output  1  one-cycle pulse: the redirect was rejected because the target is misaligned.
- o_imem_req  output  1  memory request valid.
- o_imem_addr  output  XLEN  request address (fetch PC).
- i_imem_gnt  input  1  request accepted this cycle.
- i_imem_rvalid  input  1  response valid; responses arrive in order, one per grant, at least 1 cycle after the grant.
- i_imem_rdata  input  XLEN  response instruction.
- o_inst_valid  output  1  queue head valid.
- o_inst_data  output  XLEN  head instruction.
- o_inst_pc  output  XLEN  head PC.
- i_inst_ready  input  1  consumer accepts the head.
- o_count  output  $clog2(DEPTH)+1  queue occupancy.

Behaviour:
- **Reset.**
  - fetch_pc = RESET_PC, resp_pc = RESET_PC.
  - Queue empty, outstanding = 0, drop = 0.
  - o_inst_valid = 0, o_count = 0, o_redirect_misaligned = 0.
  - o_imem_req = 0 while rst is high.
  - Reset mid-operation discards all queue contents and in-flight tracking. Responses arriving after reset for pre-reset grants are the memory's responsibility; the memory must be reset together with this block.
- **Request issue.**
  - o_imem_req = !rst && (count + outstanding) < DEPTH. This check does not credit a same-cycle pop.
  - o_imem_addr = fetch_pc.
  - A grant (req && gnt) advances fetch_pc by 4 and increments outstanding.
- **Response.**
  - On i_imem_rvalid with drop == 0, the entry {resp_pc, rdata} is pushed and resp_pc advances by 4.
  - On i_imem_rvalid with drop > 0, the response is discarded and drop decrements.
  - outstanding decrements on every rvalid.
  - A grant and an rvalid in the same cycle leave outstanding unchanged.
- **Pop.**
  - o_inst_valid && i_inst_ready removes the head.
  - Push and pop in the same cycle keep count unchanged.
  - When the queue is empty, a push is not visible at the head until the next cycle (1-cycle latency from rvalid to o_inst_valid).
- **Occupancy.** count can never exceed DEPTH, because of the credit rule. An rvalid when count == DEPTH is an assertion error.
- **Redirect** (i_redirect = 1, i_redirect_addr[1:0] == 0), highest priority. Next state:
  - Queue empty, count = 0.
  - fetch_pc = resp_pc = i_redirect_addr.
  - drop = outstanding_next, i.e. all in-flight requests, including a grant in the same cycle, minus any response consumed this cycle.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle is accepted by the consumer but has no further effect.
  - o_imem_req in the redirect cycle still shows the old fetch_pc. If granted, that request is counted in drop.
- **Misaligned redirect** (addr[1:0] != 0):
  - No flush and no PC change.
  - o_redirect_misaligned pulses high for exactly one cycle.
- **Wrap-around.** PCs wrap modulo 2^XLEN. Queue pointers wrap modulo DEPTH; count distinguishes full from empty.
- **Drop behaviour.** The drop counter saturates at DEPTH. Requests continue to issue while drop > 0, subject to the credit rule.
- **Structure.** No FSM is needed beyond the counters; all outputs except o_imem_req are registered or are direct reads of the queue head.

Test Plan:
- Streaming, DEPTH=4: 1-cycle latency memory, gnt always 1, ready always 1 → after reset, PCs 0,4,8,12,… appear on o_inst_pc with matching rdata; one instruction per cycle in steady state.
- Backpressure: ready = 0, gnt = 1 → exactly 4 grants (addresses 0..12), then o_imem_req = 0 and o_count = 4; raising ready resumes requests at 16 with no loss or duplication.
- Redirect with 3 outstanding (3-cycle latency memory) to 0x100 → next 3 responses dropped; first queued entry has pc = 0x100; o_count = 0 in the cycle after the redirect.
- Redirect to 0x102 → o_redirect_misaligned high for exactly 1 cycle; stream continues unchanged.
- Redirect in the same cycle as gnt, rvalid and pop → drop equals the new outstanding count; queue empty; first valid output pc = the redirect target.
- rst asserted asynchronously mid-stream with 2 entries queued → o_inst_valid = 0 immediately; after release, the first request address = RESET_PC.
